// File: rtl/layer_controller_pkg.sv
// Shared definitions for the layer controller: global defaults, FSM encoding
// and the width constants used by the saturating accumulate/clip datapath.
package layer_controller_pkg;

  // GlobalVariables: default geometry of one layer.
  localparam int unsigned DEF_NODES     = 10;
  localparam int unsigned DEF_IN_ADDR_W = 10;
  localparam int unsigned DEF_W_WIDTH   = 8;
  localparam int unsigned DEF_ACC_WIDTH = 16;
  localparam int unsigned DEF_OUT_WIDTH = 8;
  localparam int unsigned DEF_RELU_EN   = 1;

  // Headroom bits added above the accumulator so a single add cannot wrap
  // before the saturation check sees it.
  localparam int unsigned SAT_GUARD_W = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2,
    HOLD   = 2'd3
  } lc_state_e;

  function automatic int unsigned sat_ext_width(input int unsigned acc_width);
    return acc_width + SAT_GUARD_W;
  endfunction

endpackage

// File: rtl/layer_controller_if.sv
// Bundle of the layer controller's queue, weight-memory, bias and output
// handshake signals, with controller (master) and environment (slave) views.
interface layer_controller_if #(
  parameter int unsigned NODES     = 10,
  parameter int unsigned IN_ADDR_W = 10,
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned OUT_WIDTH = 8
);
  logic                       queueEmpty;
  logic                       queueFinished;
  logic [IN_ADDR_W-1:0]       queueOut;
  logic                       dequeue;
  logic                       weightRd;
  logic [IN_ADDR_W-1:0]       weightAddr;
  logic [NODES*W_WIDTH-1:0]   weightData;
  logic                       biasWe;
  logic [NODES*W_WIDTH-1:0]   biasIn;
  logic                       busy;
  logic                       outputsReady;
  logic                       outputsRecieved;
  logic [NODES*OUT_WIDTH-1:0] layerOutput;
  logic                       overflow;

  modport master (
    input  queueEmpty, queueFinished, queueOut, weightData, biasWe, biasIn,
           outputsRecieved,
    output dequeue, weightRd, weightAddr, busy, outputsReady, layerOutput,
           overflow
  );

  modport slave (
    output queueEmpty, queueFinished, queueOut, weightData, biasWe, biasIn,
           outputsRecieved,
    input  dequeue, weightRd, weightAddr, busy, outputsReady, layerOutput,
           overflow
  );
endinterface

// File: rtl/layer_controller_node_accumulator.sv
// One output node: saturating weight accumulator, bias register and the
// bias-add / activation / clip stage captured on the FINISH cycle.
module node_accumulator
  import layer_controller_pkg::*;
#(
  parameter int unsigned W_WIDTH   = DEF_W_WIDTH,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int unsigned RELU_EN   = DEF_RELU_EN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        acc_en,
  input  logic                        bias_we,
  input  logic                        finish,
  input  logic signed [W_WIDTH-1:0]   weight,
  input  logic signed [W_WIDTH-1:0]   bias_in,
  output logic [OUT_WIDTH-1:0]        out_q,
  output logic                        sat_o
);

  localparam int unsigned EXT_W = sat_ext_width(ACC_WIDTH);

  localparam logic signed [EXT_W-1:0] ACC_MAX =
    {{(SAT_GUARD_W+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] ACC_MIN =
    {{(SAT_GUARD_W+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] UMAX =
    {{(EXT_W-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};
  localparam logic signed [EXT_W-1:0] SMAX =
    {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SMIN =
    {{(EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [W_WIDTH-1:0]   bias_q, bias_d;
  logic [OUT_WIDTH-1:0]        out_d;

  logic signed [EXT_W-1:0]     acc_sum, fin_sum, fin_val;
  logic signed [ACC_WIDTH-1:0] acc_new;
  logic [OUT_WIDTH-1:0]        out_new;
  logic                        acc_sat, fin_sat, clip;

  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(
    input logic signed [EXT_W-1:0] v
  );
    if (v > ACC_MAX)      return ACC_MAX[ACC_WIDTH-1:0];
    else if (v < ACC_MIN) return ACC_MIN[ACC_WIDTH-1:0];
    else                  return v[ACC_WIDTH-1:0];
  endfunction

  always_comb begin
    acc_sum = EXT_W'(acc_q) + EXT_W'(weight);
    acc_sat = (acc_sum > ACC_MAX) || (acc_sum < ACC_MIN);
    acc_new = sat_acc(acc_sum);

    fin_sum = EXT_W'(acc_q) + EXT_W'(bias_q);
    fin_sat = (fin_sum > ACC_MAX) || (fin_sum < ACC_MIN);
    fin_val = EXT_W'(sat_acc(fin_sum));

    // ReLU clamping of negatives is the activation itself, not a clip.
    clip    = 1'b0;
    out_new = fin_val[OUT_WIDTH-1:0];
    if (RELU_EN != 0) begin
      if (fin_val[EXT_W-1]) begin
        out_new = '0;
      end else if (fin_val > UMAX) begin
        out_new = '1;
        clip    = 1'b1;
      end
    end else begin
      if (fin_val > SMAX) begin
        out_new = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        clip    = 1'b1;
      end else if (fin_val < SMIN) begin
        out_new = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        clip    = 1'b1;
      end
    end
  end

  always_comb begin
    acc_d  = acc_q;
    bias_d = bias_q;
    out_d  = out_q;
    if (clear)       acc_d = '0;
    else if (acc_en) acc_d = acc_new;
    if (bias_we)     bias_d = bias_in;
    if (finish)      out_d = out_new;
  end

  assign sat_o = (acc_en & acc_sat) | (finish & (fin_sat | clip));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      bias_q <= '0;
      out_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      bias_q <= bias_d;
      out_q  <= out_d;
    end
  end

endmodule

// File: rtl/layer_controller.sv
// Layer controller: drains the input-index queue into per-node weight
// accumulators, then biases/activates and holds the result until acknowledged.
module layer_controller
  import layer_controller_pkg::*;
#(
  parameter int unsigned NODES     = DEF_NODES,
  parameter int unsigned IN_ADDR_W = DEF_IN_ADDR_W,
  parameter int unsigned W_WIDTH   = DEF_W_WIDTH,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int unsigned RELU_EN   = DEF_RELU_EN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       queueEmpty,
  input  logic                       queueFinished,
  input  logic [IN_ADDR_W-1:0]       queueOut,
  output logic                       dequeue,
  output logic                       weightRd,
  output logic [IN_ADDR_W-1:0]       weightAddr,
  input  logic [NODES*W_WIDTH-1:0]   weightData,
  input  logic                       biasWe,
  input  logic [NODES*W_WIDTH-1:0]   biasIn,
  output logic                       busy,
  output logic                       outputsReady,
  input  logic                       outputsRecieved,
  output logic [NODES*OUT_WIDTH-1:0] layerOutput,
  output logic                       overflow
);

  lc_state_e        state_q, state_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ready_q, ready_d;
  logic             ovf_q, ovf_d;
  logic             rd_req;
  logic             clear;
  logic             finish;
  logic             bias_we_idle;
  logic [NODES-1:0] node_sat;

  // Reads are issued straight off the FWFT head, one index per cycle.
  assign rd_req       = (state_q == ACCUM) && !queueEmpty;
  assign dequeue      = rd_req;
  assign weightRd     = rd_req;
  assign weightAddr   = queueOut;

  assign clear        = (state_q == HOLD) && outputsRecieved;
  assign finish       = (state_q == FINISH);
  assign bias_we_idle = (state_q == IDLE) && biasWe;

  assign busy         = (state_q != IDLE);
  assign outputsReady = ready_q;
  assign overflow     = ovf_q;

  always_comb begin
    state_d    = state_q;
    rd_valid_d = rd_req;
    ready_d    = ready_q;
    ovf_d      = ovf_q | (|node_sat);
    unique case (state_q)
      IDLE: begin
        if (!queueEmpty || queueFinished) state_d = ACCUM;
      end
      ACCUM: begin
        // Leave only once the last read's data has been accumulated.
        if (queueFinished && queueEmpty && !rd_valid_q) state_d = FINISH;
      end
      FINISH: begin
        ready_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (outputsRecieved) begin
          ready_d = 1'b0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      ready_q    <= ready_d;
      ovf_q      <= ovf_d;
    end
  end

  for (genvar n = 0; n < NODES; n++) begin : g_node
    node_accumulator #(
      .W_WIDTH   (W_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .RELU_EN   (RELU_EN)
    ) u_node (
      .clk     (clk),
      .rst_n   (reset),
      .clear   (clear),
      .acc_en  (rd_valid_q),
      .bias_we (bias_we_idle),
      .finish  (finish),
      .weight  (weightData[n*W_WIDTH +: W_WIDTH]),
      .bias_in (biasIn[n*W_WIDTH +: W_WIDTH]),
      .out_q   (layerOutput[n*OUT_WIDTH +: OUT_WIDTH]),
      .sat_o   (node_sat[n])
    );
  end

endmodule

// File: tb/tb_layer_controller.sv
// Scoreboard bench for layer_controller: ReLU and identity instances share
// one queue/bias stimulus stream; results are checked when outputsReady rises.
module tb_layer_controller;

  localparam int unsigned NODES = 2;
  localparam int unsigned AW    = 10;
  localparam int unsigned WW    = 8;
  localparam int unsigned OW    = 8;
  localparam int unsigned ACCW  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer_controller_if #(.NODES(NODES), .IN_ADDR_W(AW), .W_WIDTH(WW), .OUT_WIDTH(OW)) bus_r ();
  layer_controller_if #(.NODES(NODES), .IN_ADDR_W(AW), .W_WIDTH(WW), .OUT_WIDTH(OW)) bus_i ();

  assign bus_i.queueEmpty      = bus_r.queueEmpty;
  assign bus_i.queueFinished   = bus_r.queueFinished;
  assign bus_i.queueOut        = bus_r.queueOut;
  assign bus_i.biasWe          = bus_r.biasWe;
  assign bus_i.biasIn          = bus_r.biasIn;
  assign bus_i.outputsRecieved = bus_r.outputsRecieved;

  layer_controller #(
    .NODES(NODES), .IN_ADDR_W(AW), .W_WIDTH(WW), .ACC_WIDTH(ACCW),
    .OUT_WIDTH(OW), .RELU_EN(1)
  ) dut_relu (
    .clk(clk), .reset(rst_n),
    .queueEmpty(bus_r.queueEmpty), .queueFinished(bus_r.queueFinished),
    .queueOut(bus_r.queueOut), .dequeue(bus_r.dequeue),
    .weightRd(bus_r.weightRd), .weightAddr(bus_r.weightAddr),
    .weightData(bus_r.weightData), .biasWe(bus_r.biasWe), .biasIn(bus_r.biasIn),
    .busy(bus_r.busy), .outputsReady(bus_r.outputsReady),
    .outputsRecieved(bus_r.outputsRecieved), .layerOutput(bus_r.layerOutput),
    .overflow(bus_r.overflow)
  );

  layer_controller #(
    .NODES(NODES), .IN_ADDR_W(AW), .W_WIDTH(WW), .ACC_WIDTH(ACCW),
    .OUT_WIDTH(OW), .RELU_EN(0)
  ) dut_ident (
    .clk(clk), .reset(rst_n),
    .queueEmpty(bus_i.queueEmpty), .queueFinished(bus_i.queueFinished),
    .queueOut(bus_i.queueOut), .dequeue(bus_i.dequeue),
    .weightRd(bus_i.weightRd), .weightAddr(bus_i.weightAddr),
    .weightData(bus_i.weightData), .biasWe(bus_i.biasWe), .biasIn(bus_i.biasIn),
    .busy(bus_i.busy), .outputsReady(bus_i.outputsReady),
    .outputsRecieved(bus_i.outputsRecieved), .layerOutput(bus_i.layerOutput),
    .overflow(bus_i.overflow)
  );

  // Weight memory contents, node 0 in the low byte.
  function automatic logic [NODES*WW-1:0] row(input logic [AW-1:0] a);
    case (a)
      10'd1:   return {8'h7F, 8'h7F};
      10'd3:   return {8'h02, 8'h0A};
      10'd7:   return {8'hFE, 8'hFC};
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) if (bus_r.weightRd) bus_r.weightData <= row(bus_r.weightAddr);
  always @(posedge clk) if (bus_i.weightRd) bus_i.weightData <= row(bus_i.weightAddr);

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [15:0] out_r;
    logic [15:0] out_i;
    logic        ovf;
  } exp_t;

  exp_t            sb[$];
  logic [AW-1:0]   idx_q[$];

  task automatic push_exp(input string tag, input logic [15:0] r, input logic [15:0] i,
                          input logic ovf);
    exp_t e;
    e.tag = tag; e.out_r = r; e.out_i = i; e.ovf = ovf;
    sb.push_back(e);
  endtask

  task automatic q_drive();
    bus_r.queueEmpty = (idx_q.size() == 0);
    bus_r.queueOut   = (idx_q.size() != 0) ? idx_q[0] : '0;
  endtask

  task automatic tick();
    logic dq;
    @(negedge clk);
    dq = bus_r.dequeue;
    @(posedge clk);
    #1;
    if (dq && idx_q.size() != 0) void'(idx_q.pop_front());
    q_drive();
  endtask

  task automatic wait_result();
    exp_t e;
    int   n;
    n = 0;
    while (!bus_r.outputsReady && n < 2000) begin
      tick();
      n++;
    end
    e = sb.pop_front();
    check_val({e.tag, "_rdy_r"}, 64'(bus_r.outputsReady), 64'd1);
    check_val({e.tag, "_rdy_i"}, 64'(bus_i.outputsReady), 64'd1);
    check_val({e.tag, "_out_r"}, 64'(bus_r.layerOutput), 64'(e.out_r));
    check_val({e.tag, "_out_i"}, 64'(bus_i.layerOutput), 64'(e.out_i));
    check_val({e.tag, "_ovf_r"}, 64'(bus_r.overflow), 64'(e.ovf));
    check_val({e.tag, "_ovf_i"}, 64'(bus_i.overflow), 64'(e.ovf));
  endtask

  task automatic ack();
    bus_r.outputsRecieved = 1'b1;
    bus_r.queueFinished   = 1'b0;
    tick();
    bus_r.outputsRecieved = 1'b0;
    check_val("ack_rdy", 64'(bus_r.outputsReady), 64'd0);
    check_val("ack_busy", 64'(bus_r.busy), 64'd0);
    check_val("ack_ovf", 64'(bus_i.overflow), 64'd0);
  endtask

  task automatic start_frame(input int unsigned a, input int unsigned b);
    idx_q.push_back(AW'(a));
    idx_q.push_back(AW'(b));
    bus_r.queueFinished = 1'b1;
    q_drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus_r.queueFinished   = 1'b0;
    bus_r.biasWe          = 1'b0;
    bus_r.biasIn          = '0;
    bus_r.outputsRecieved = 1'b0;
    q_drive();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 64'(bus_r.busy), 64'd0);
    check_val("rst_rdy", 64'(bus_r.outputsReady), 64'd0);
    check_val("rst_out", 64'(bus_i.layerOutput), 64'd0);
    check_val("rst_ovf", 64'(bus_r.overflow), 64'd0);
    rst_n = 1'b1;
    tick();

    // Biases {5,-3}
    bus_r.biasIn = {8'hFD, 8'h05};
    bus_r.biasWe = 1'b1;
    tick();
    bus_r.biasWe = 1'b0;

    // Basic frame: indices 3 then 7
    push_exp("basic", 16'h000B, 16'hFD0B, 1'b0);
    start_frame(3, 7);
    wait_result();
    ack();

    // Bias write during ACCUM must be ignored
    push_exp("bias_ign", 16'h000B, 16'hFD0B, 1'b0);
    start_frame(3, 7);
    tick();
    check_val("bias_ign_busy", 64'(bus_r.busy), 64'd1);
    bus_r.biasIn = {8'd100, 8'd100};
    bus_r.biasWe = 1'b1;
    tick();
    bus_r.biasWe = 1'b0;
    wait_result();
    ack();

    // Empty frame: bias-only, ready two cycles after leaving IDLE
    push_exp("empty", 16'h0005, 16'hFD05, 1'b0);
    bus_r.queueFinished = 1'b1;
    q_drive();
    n = 0;
    do begin tick(); n++; end while (!bus_r.busy && n < 50);
    n = 0;
    while (!bus_r.outputsReady && n < 50) begin tick(); n++; end
    check_val("empty_lat", 64'(n), 64'd2);
    wait_result();
    ack();

    // Saturation: 300 x weight 127
    push_exp("sat", 16'hFFFF, 16'h7F7F, 1'b1);
    repeat (300) idx_q.push_back(AW'(1));
    bus_r.queueFinished = 1'b1;
    q_drive();
    wait_result();
    ack();

    // HOLD with pending queue entries and no acknowledge
    push_exp("hold", 16'h000B, 16'hFD0B, 1'b0);
    start_frame(3, 7);
    wait_result();
    bus_r.queueFinished = 1'b0;
    idx_q.push_back(AW'(3));
    q_drive();
    for (int k = 0; k < 20; k++) begin
      check_val("hold_deq", 64'(bus_r.dequeue), 64'd0);
      check_val("hold_out", 64'(bus_i.layerOutput), 64'hFD0B);
      tick();
    end
    check_val("hold_busy", 64'(bus_r.busy), 64'd1);
    check_val("hold_qlen", 64'(idx_q.size()), 64'd1);
    push_exp("after_hold", 16'h000F, 16'hFF0F, 1'b0);
    bus_r.queueFinished   = 1'b1;
    bus_r.outputsRecieved = 1'b1;
    tick();
    bus_r.outputsRecieved = 1'b0;
    check_val("after_hold_idle", 64'(bus_r.busy), 64'd0);
    wait_result();
    ack();

    // Reset pulse mid-ACCUM
    repeat (10) idx_q.push_back(AW'(3));
    bus_r.queueFinished = 1'b0;
    q_drive();
    tick();
    tick();
    check_val("mid_busy", 64'(bus_r.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("mrst_busy", 64'(bus_r.busy), 64'd0);
    check_val("mrst_deq", 64'(bus_r.dequeue), 64'd0);
    check_val("mrst_rd", 64'(bus_i.weightRd), 64'd0);
    check_val("mrst_rdy", 64'(bus_r.outputsReady), 64'd0);
    check_val("mrst_out_r", 64'(bus_r.layerOutput), 64'd0);
    check_val("mrst_out_i", 64'(bus_i.layerOutput), 64'd0);
    check_val("mrst_ovf", 64'(bus_r.overflow), 64'd0);
    idx_q.delete();
    q_drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_exp("post_rst", 16'h0000, 16'h0000, 1'b0);
    bus_r.queueFinished = 1'b1;
    q_drive();
    wait_result();
    ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
